forward_cell_link_nway: RTL and testbench

- Parametrised successor of the cell-link forwarder. Merges NUM_INPUTS valid-only 32-bit packet streams (incoming cell link plus local BPM/FMPS sources) onto one outgoing cell stream.
- Internal packet-mode FIFOs and a round-robin packet arbiter replace the external mux IP.
- Duplicate suppression per FA interval uses per-protocol cell bitmaps.
- Sits between Aurora RX/local packetisers and Aurora TX in the auroraUserClk domain.

---
 rtl/forward_cell_link_nway.sv | 235 +++++++++++++++++++++++
 tb/tb_forward_cell_link_nway.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/forward_cell_link_nway.sv
// forward_cell_link_nway: merges NUM_INPUTS packet streams onto one cell link.
// Define FORWARD_CELL_LINK_FMPS_EN to also forward FMPS packets once per FA interval.
module forward_cell_link_nway #(
  parameter int          NUM_INPUTS       = 3,
  parameter int          FIFO_AW          = 8,
  parameter int          MAX_CELLS        = 32,
  parameter int          MAX_PACKET_WORDS = 128,
  parameter int          FLUSH_CYCLES     = 16,
  parameter logic [15:0] FOFB_MAGIC       = 16'hA5BE,
  parameter logic [15:0] FMPS_MAGIC       = 16'hB6CF
) (
  input  logic                    auroraUserClk,
  input  logic                    auroraReset,
  input  logic                    auroraFAstrobe,
  input  logic [NUM_INPUTS-1:0]   rxTVALID,
  input  logic [NUM_INPUTS-1:0]   rxTLAST,
  input  logic [32*NUM_INPUTS-1:0] rxTDATA,
  input  logic [NUM_INPUTS-1:0]   rxErrFlag,
  output logic                    cellLinkTxTVALID,
  output logic                    cellLinkTxTLAST,
  output logic [31:0]             cellLinkTxTDATA,
  output logic [NUM_INPUTS-1:0]   rxDropPulse
);
  localparam int CIW   = $clog2(MAX_CELLS);
  localparam int GW    = $clog2(NUM_INPUTS);
  localparam int CW    = $clog2(MAX_PACKET_WORDS);
  localparam int FW    = $clog2(FLUSH_CYCLES + 1);
  localparam int DEPTH = 1 << FIFO_AW;

  localparam logic [1:0] S_HDR  = 2'd0;
  localparam logic [1:0] S_PKT  = 2'd1;
  localparam logic [1:0] S_SKIP = 2'd2;
  localparam logic [1:0] S_SYNC = 2'd3;

  localparam logic [1:0] A_IDLE  = 2'd0;
  localparam logic [1:0] A_HDR   = 2'd1;
  localparam logic [1:0] A_FWD   = 2'd2;
  localparam logic [1:0] A_DRAIN = 2'd3;

  logic [1:0]                   st;
  logic [GW-1:0]                grant, pick, cand;
  logic                         found, pop;
  logic [CW-1:0]                cnt;
  logic [FW-1:0]                flush_cnt;
  logic [NUM_INPUTS-1:0]        avail;
  logic [NUM_INPUTS-1:0][32:0]  heads;
  logic [32:0]                  head;
  logic [MAX_CELLS-1:0]         bm;
  logic [15:0]                  magic;
  logic [CIW-1:0]               cidx;
  logic                         fofb_ok, fmps_ok, fwd;
  logic                         ov, ol;
  logic [31:0]                  od;
  logic                         unused_bits;

  assign pop   = (st != A_IDLE) && !auroraFAstrobe;
  assign head  = heads[grant];
  assign magic = head[31:16];
  assign cidx  = head[10+:CIW];
  assign unused_bits = ^head[15:0];

  for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_in
    logic [32:0]      mem [DEPTH];
    logic [FIFO_AW:0] wr, cm, rd, wr_n, cm_n;
    logic [1:0]       sy, sy_n;
    logic             wen, drop, drop_n, full, v, l;
    logic [31:0]      din;

    assign v = rxTVALID[g];
    assign l = rxTLAST[g];
    // bit 30 marks a packet whose CRC check failed upstream
    assign din = {rxTDATA[32*g+31],
                  rxTDATA[32*g+30] | (l & rxErrFlag[g]),
                  rxTDATA[32*g+:30]};
    assign full = (wr[FIFO_AW] != rd[FIFO_AW]) &&
                  (wr[FIFO_AW-1:0] == rd[FIFO_AW-1:0]);
    assign avail[g]       = rd != cm;
    assign heads[g]       = mem[rd[FIFO_AW-1:0]];
    assign rxDropPulse[g] = drop;

    always_comb begin
      wen    = 1'b0;
      wr_n   = wr;
      cm_n   = cm;
      sy_n   = sy;
      drop_n = 1'b0;
      if (flush_cnt == '0) begin
        case (sy)
          S_SYNC: if (!v || l) sy_n = S_HDR;
          S_HDR: if (v && !l) begin
            if (full) begin
              drop_n = 1'b1;
              sy_n   = S_SKIP;
            end else begin
              wen  = 1'b1;
              wr_n = wr + 1'b1;
              sy_n = S_PKT;
            end
          end
          S_PKT: if (v) begin
            if (full) begin
              drop_n = 1'b1;
              wr_n   = cm;
              sy_n   = l ? S_HDR : S_SKIP;
            end else begin
              wen  = 1'b1;
              wr_n = wr + 1'b1;
              if (l) begin
                cm_n = wr + 1'b1;
                sy_n = S_HDR;
              end
            end
          end
          default: if (v && l) sy_n = S_HDR;
        endcase
      end
    end

    always_ff @(posedge auroraUserClk) begin
      if (auroraReset) begin
        wr   <= '0;
        cm   <= '0;
        rd   <= '0;
        sy   <= S_HDR;
        drop <= 1'b0;
      end else if (auroraFAstrobe) begin
        wr   <= '0;
        cm   <= '0;
        rd   <= '0;
        sy   <= S_SYNC;
        drop <= 1'b0;
      end else begin
        wr   <= wr_n;
        cm   <= cm_n;
        sy   <= sy_n;
        drop <= drop_n;
        if (pop && grant == GW'(g)) rd <= rd + 1'b1;
      end
    end

    always_ff @(posedge auroraUserClk) begin
      if (wen) mem[wr[FIFO_AW-1:0]] <= {l, din};
    end
  end

  always_comb begin
    pick  = grant;
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k <= NUM_INPUTS; k++) begin
      cand = GW'((int'(grant) + k) % NUM_INPUTS);
      if (!found && avail[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  assign fofb_ok = (magic == FOFB_MAGIC) && !bm[cidx];

`ifdef FORWARD_CELL_LINK_FMPS_EN
  logic [MAX_CELLS-1:0] fbm;
  assign fmps_ok = (magic == FMPS_MAGIC) && !fbm[cidx];
  always_ff @(posedge auroraUserClk) begin
    if (auroraReset || auroraFAstrobe) fbm <= '0;
    else if (st == A_HDR && fmps_ok) fbm[cidx] <= 1'b1;
  end
`else
  logic unused_fmps;
  assign fmps_ok     = 1'b0;
  assign unused_fmps = ^FMPS_MAGIC;
`endif

  assign fwd = fofb_ok | fmps_ok;

  always_ff @(posedge auroraUserClk) begin
    if (auroraReset) begin
      st        <= A_IDLE;
      grant     <= '0;
      cnt       <= '0;
      bm        <= '0;
      ov        <= 1'b0;
      ol        <= 1'b0;
      od        <= '0;
      flush_cnt <= '0;
    end else if (auroraFAstrobe) begin
      st        <= A_IDLE;
      cnt       <= '0;
      bm        <= '0;
      ov        <= 1'b0;
      ol        <= 1'b0;
      flush_cnt <= FW'(FLUSH_CYCLES);
    end else begin
      ov <= 1'b0;
      ol <= 1'b0;
      if (flush_cnt != '0) flush_cnt <= flush_cnt - 1'b1;
      case (st)
        A_IDLE: if (found) begin
          grant <= pick;
          st    <= A_HDR;
        end
        A_HDR: begin
          if (fofb_ok) bm[cidx] <= 1'b1;
          if (fwd) begin
            ov  <= 1'b1;
            od  <= head[31:0];
            cnt <= CW'(1);
            st  <= A_FWD;
          end else begin
            st <= A_DRAIN;
          end
        end
        A_FWD: begin
          ov <= 1'b1;
          od <= head[31:0];
          if (head[32]) begin
            ol <= 1'b1;
            st <= A_IDLE;
          end else if (cnt == CW'(MAX_PACKET_WORDS - 1)) begin
            // over-long packet: close it here, discard the tail
            ol <= 1'b1;
            st <= A_DRAIN;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: if (head[32]) st <= A_IDLE;
      endcase
    end
  end

  assign cellLinkTxTVALID = ov;
  assign cellLinkTxTLAST  = ol;
  assign cellLinkTxTDATA  = od;
endmodule

// File: tb/tb_forward_cell_link_nway.sv
// Bench for forward_cell_link_nway: directed cases with literal expectations,
// then randomized packets checked against a packet-level model.
module tb_forward_cell_link_nway;
  localparam int N    = 3;
  localparam int MAXW = 128;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst, fa;
  logic [N-1:0]   v, l, er;
  logic [32*N-1:0] d;
  logic           ov, ol;
  logic [31:0]    od;
  logic [N-1:0]   drop;

  int vectors = 0;
  int miscompares = 0;
  logic [32:0] exp_q[$];
  logic [32:0] e_w;
  bit fa_s, rst_s, in_pkt;
  int drop_seen[N];
  int drop_exp[N];
  bit [31:0] bm;
`ifdef FORWARD_CELL_LINK_FMPS_EN
  bit [31:0] fbm;
`endif

  forward_cell_link_nway dut (
    .auroraUserClk    (clk),
    .auroraReset      (rst),
    .auroraFAstrobe   (fa),
    .rxTVALID         (v),
    .rxTLAST          (l),
    .rxTDATA          (d),
    .rxErrFlag        (er),
    .cellLinkTxTVALID (ov),
    .cellLinkTxTLAST  (ol),
    .cellLinkTxTDATA  (od),
    .rxDropPulse      (drop)
  );

  always @(posedge clk) begin
    fa_s  = fa;
    rst_s = rst;
  end

  always @(negedge clk) begin
    if (!rst_s) begin
      for (int i = 0; i < N; i++) if (drop[i]) drop_seen[i]++;
      if (fa_s) begin
        vectors++;
        if (ov || ol) begin
          miscompares++;
          $display("FAIL strobe_quiet: valid=%0b last=%0b, required 0 0", ov, ol);
        end
        exp_q.delete();
        in_pkt = 0;
      end else if (ov) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_word: got data=%h last=%0b, required no output", od, ol);
        end else begin
          e_w = exp_q.pop_front();
          if ({ol, od} !== e_w) begin
            miscompares++;
            $display("FAIL word: got last=%0b data=%h, required last=%0b data=%h",
                     ol, od, e_w[32], e_w[31:0]);
          end
        end
        in_pkt = !ol;
      end else if (in_pkt) begin
        vectors++;
        miscompares++;
        $display("FAIL gap: valid=0 inside packet, required 1");
        in_pkt = 0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic strobe();
    @(posedge clk);
    #1 fa = 1'b1;
    @(posedge clk);
    #1 fa = 1'b0;
  endtask

  task automatic send_pkt(input int ch, input logic [31:0] w[$],
                          input bit e, input bit keep);
    for (int k = 0; k < w.size(); k++) begin
      @(posedge clk);
      #1;
      v[ch] = 1'b1;
      d[32*ch+:32] = w[k];
      l[ch] = (k == w.size() - 1);
      er[ch] = l[ch] ? e : 1'($urandom);
    end
    if (!keep) begin
      @(posedge clk);
      #1;
      v[ch] = 1'b0;
      l[ch] = 1'b0;
      er[ch] = 1'b0;
    end
  endtask

  task automatic mk(input logic [31:0] hdr, input int n, input logic [31:0] base,
                    output logic [31:0] w[$]);
    w.delete();
    w.push_back(hdr);
    for (int k = 1; k < n; k++) w.push_back(base + 32'(k));
  endtask

  task automatic expect_pkt(input logic [31:0] w[$]);
    for (int k = 0; k < w.size(); k++)
      exp_q.push_back({k == w.size() - 1, w[k]});
  endtask

  task automatic check_done(input string name);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s: %0d expected words missing, required 0", name, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic check_val(input string name, input logic [31:0] got,
                           input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", name, got, want);
    end
  endtask

  // Packet-level reference: classify by magic and per-interval cell bitmaps.
  task automatic model_pkt(input logic [31:0] w[$], input bit e);
    logic [31:0] x[$];
    logic [15:0] mg;
    logic [4:0]  ix;
    bit          f;
    int          n;
    x = w;
    if (x.size() < 2) return;
    if (e) x[x.size()-1][30] = 1'b1;
    mg = x[0][31:16];
    ix = x[0][14:10];
    f = 0;
    if (mg == 16'hA5BE && !bm[ix]) begin
      bm[ix] = 1'b1;
      f = 1;
    end
`ifdef FORWARD_CELL_LINK_FMPS_EN
    else if (mg == 16'hB6CF && !fbm[ix]) begin
      fbm[ix] = 1'b1;
      f = 1;
    end
`endif
    if (f) begin
      n = (x.size() < MAXW) ? x.size() : MAXW;
      for (int k = 0; k < n; k++) exp_q.push_back({k == n - 1, x[k]});
    end
  endtask

  task automatic clear_model();
    bm = '0;
`ifdef FORWARD_CELL_LINK_FMPS_EN
    fbm = '0;
`endif
  endtask

  logic [31:0] w0[$], w1[$], w2[$];

  initial begin
    rst = 1'b1; fa = 1'b0; v = '0; l = '0; er = '0; d = '0;
    for (int i = 0; i < N; i++) begin drop_seen[i] = 0; drop_exp[i] = 0; end
    clear_model();
    repeat (3) @(posedge clk);
    #1 fa = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0; fa = 1'b0;
    @(negedge clk);
    check_val("rst_valid", 32'(ov), 32'd0);
    check_val("rst_last", 32'(ol), 32'd0);
    check_val("rst_data", od, 32'd0);
    check_val("rst_drop", 32'(drop), 32'd0);

    // single packet right after reset (strobe during reset must be ignored)
    w0 = {32'hA5BE0C00, 32'h1, 32'h2, 32'h3};
    expect_pkt(w0);
    send_pkt(1, w0, 0, 0);
    tick(10);
    check_done("t1_basic");

    // duplicate cell in same interval, then again after strobe
    strobe(); tick(25);
    w0 = {32'hA5BE0C00, 32'h11};
    expect_pkt(w0);
    send_pkt(0, w0, 0, 0);
    tick(8);
    w0 = {32'hA5BE0C00, 32'h22};
    send_pkt(2, w0, 0, 0);
    tick(10);
    check_done("t2_dup");
    strobe(); tick(25);
    w0 = {32'hA5BE0C00, 32'h33};
    expect_pkt(w0);
    send_pkt(2, w0, 0, 0);
    tick(10);
    check_done("t2_new_interval");

    // round robin: last grant 0, so order is 1, 2, 0
    strobe(); tick(25);
    w0 = {32'h12340000, 32'h5};
    send_pkt(0, w0, 0, 0);
    tick(10);
    w0 = {32'hA5BE0400, 32'h11, 32'h12};
    w1 = {32'hA5BE0800, 32'h21, 32'h22};
    w2 = {32'hA5BE0C00, 32'h31, 32'h32};
    expect_pkt(w1); expect_pkt(w2); expect_pkt(w0);
    fork
      send_pkt(0, w0, 0, 0);
      send_pkt(1, w1, 0, 0);
      send_pkt(2, w2, 0, 0);
    join
    tick(20);
    check_done("t3_round_robin");

    // error flag on last word
    w0 = {32'hA5BE1000, 32'h00000005};
    w1 = {32'hA5BE1000, 32'h40000005};
    expect_pkt(w1);
    send_pkt(0, w0, 1, 0);
    tick(10);
    check_done("t4_err_flag");

    // overflow on input 1, then an intact packet
    mk(32'hA5BE1400, 300, 32'h100, w0);
    send_pkt(1, w0, 0, 0);
    tick(10);
    check_val("t5_drop_count", 32'(drop_seen[1]), 32'd1);
    drop_exp[1] = 1;
    w0 = {32'hA5BE1800, 32'h7, 32'h8};
    expect_pkt(w0);
    send_pkt(1, w0, 0, 0);
    tick(10);
    check_done("t5_after_drop");

    // strobe mid-packet, flush window and resync
    mk(32'hA5BE1C00, 10, 32'h200, w0);
    expect_pkt(w0);
    send_pkt(1, w0, 0, 0);
    tick(3);
    strobe();
    mk(32'hA5BE2000, 5, 32'h300, w1);
    mk(32'hA5BE2400, 13, 32'h400, w2);
    fork
      send_pkt(2, w1, 0, 0);
      begin
        repeat (7) @(posedge clk);
        w0 = {32'hA5BE2800, 32'h1, 32'h2};
        expect_pkt(w0);
        send_pkt(0, w2, 0, 1);
        send_pkt(0, w0, 0, 0);
      end
    join
    tick(15);
    check_done("t6_flush_resync");

    // FMPS packets
    w0 = {32'hB6CF0400, 32'h9, 32'hA};
`ifdef FORWARD_CELL_LINK_FMPS_EN
    expect_pkt(w0);
`endif
    send_pkt(1, w0, 0, 0);
    tick(10);
    check_done("t6_fmps_first");
    send_pkt(2, w0, 0, 0);
    tick(10);
    check_done("t6_fmps_repeat");

    // randomized packets against the model
    strobe(); clear_model(); tick(25);
    for (int p = 0; p < 150; p++) begin
      int ch, len;
      bit e;
      logic [15:0] mg;
      logic [31:0] h;
      if ($urandom_range(0, 9) == 0) begin
        strobe(); clear_model(); tick(25);
      end
      ch  = $urandom_range(0, N - 1);
      len = ($urandom_range(0, 19) == 0) ? $urandom_range(126, 131)
                                         : $urandom_range(1, 10);
      case ($urandom_range(0, 3))
        0, 1: mg = 16'hA5BE;
        2: mg = 16'hB6CF;
        default: mg = 16'($urandom);
      endcase
      h = {mg, 1'($urandom), 5'($urandom_range(0, 7)), 10'($urandom)};
      w0.delete();
      w0.push_back(h);
      for (int k = 1; k < len; k++) w0.push_back($urandom);
      e = ($urandom_range(0, 4) == 0);
      model_pkt(w0, e);
      send_pkt(ch, w0, e, 0);
      tick(len + 10);
      check_done("rand_pkt");
    end

    for (int i = 0; i < N; i++)
      check_val("drop_total", 32'(drop_seen[i]), 32'(drop_exp[i]));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
